// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg
// Instruction-set constants for the ELDT15 MIPS core. The control decoder and
// the program-loading encoder both import this package, so the encoding is
// defined in only one place.
//   - opcode and funct field values
//   - bit positions and widths of the 32-bit instruction fields
//   - symbolic operation enum used on the loader front end (in_op)
//   - encoder FSM state enum
package mips_isa_pkg;

  // Field widths
  localparam int OPCODE_W = 6;
  localparam int REG_W    = 5;
  localparam int FUNCT_W  = 6;
  localparam int IMM_W    = 16;
  localparam int OP_W     = 3;

  // Field least-significant bit positions inside the 32-bit word
  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_LSB    = 0;

  // Opcodes
  localparam logic [OPCODE_W-1:0] OPC_R_TYPE = 6'd15;
  localparam logic [OPCODE_W-1:0] OPC_LW     = 6'd16;
  localparam logic [OPCODE_W-1:0] OPC_SW     = 6'd17;

  // R-type function codes
  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'd32;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'd34;
  localparam logic [FUNCT_W-1:0] FUNCT_MUL = 6'd50;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'd36;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'd37;

  // Symbolic operations presented by the loader
  typedef enum logic [OP_W-1:0] {
    OP_ADD     = 3'd0,
    OP_SUB     = 3'd1,
    OP_MUL     = 3'd2,
    OP_AND     = 3'd3,
    OP_OR      = 3'd4,
    OP_LW      = 3'd5,
    OP_SW      = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_e;

  // Encoder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } enc_state_e;

endpackage

// File: rtl/instr_pack.sv
// instr_pack
// Purely combinational packer: symbolic operation plus register/immediate
// fields in, 32-bit machine word out.
//   op    in  3   symbolic operation (op_e encoding)
//   rs    in  5   source register
//   rt    in  5   second source (R-type) / destination or data register (I-type)
//   rd    in  5   destination register, R-type only
//   imm   in  16  immediate, I-type only
//   word  out 32  packed instruction (all zero for an illegal op)
//   legal out 1   op is encodable
module instr_pack
  import mips_isa_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic [REG_W-1:0] rd,
  input  logic [IMM_W-1:0] imm,
  output logic [31:0]      word,
  output logic             legal
);

  logic [FUNCT_W-1:0] funct;

  always_comb begin
    funct = FUNCT_ADD;
    case (op_e'(op))
      OP_SUB:  funct = FUNCT_SUB;
      OP_MUL:  funct = FUNCT_MUL;
      OP_AND:  funct = FUNCT_AND;
      OP_OR:   funct = FUNCT_OR;
      default: funct = FUNCT_ADD;
    endcase
  end

  always_comb begin
    word  = '0;
    legal = 1'b1;
    word[RS_LSB +: REG_W] = rs;
    word[RT_LSB +: REG_W] = rt;
    case (op_e'(op))
      OP_LW: begin
        word[OPCODE_LSB +: OPCODE_W] = OPC_LW;
        word[IMM_LSB +: IMM_W]       = imm;
      end
      OP_SW: begin
        word[OPCODE_LSB +: OPCODE_W] = OPC_SW;
        word[IMM_LSB +: IMM_W]       = imm;
      end
      OP_ILLEGAL: begin
        word  = '0;
        legal = 1'b0;
      end
      default: begin
        // R-type: shamt field [10:6] stays zero
        word[OPCODE_LSB +: OPCODE_W] = OPC_R_TYPE;
        word[RD_LSB +: REG_W]        = rd;
        word[FUNCT_LSB +: FUNCT_W]   = funct;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder
// Program-loading encoder: accepts symbolic instructions over valid/ready,
// packs them and writes them to instruction memory at sequential addresses
// starting from 0 after each start pulse.
//   clk        in  1         rising-edge clock
//   rst_n      in  1         asynchronous active-low reset
//   start      in  1         begin (or restart) loading at address 0
//   clear      in  1         abort and return to IDLE
//   in_valid   in  1         instruction valid
//   in_ready   out 1         instruction accepted this cycle if in_valid
//   in_op      in  3         symbolic operation
//   in_rs/rt/rd in 5         register fields
//   in_imm     in  16        immediate
//   imem_we    out 1         single-cycle write strobe
//   imem_addr  out ADDR_W    write address
//   imem_wdata out 32        encoded instruction
//   count      out ADDR_W+1  words written since start
//   done       out 1         memory image full
//   err        out 1         sticky illegal-op flag
module instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [REG_W-1:0]  in_rs,
  input  logic [REG_W-1:0]  in_rt,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [IMM_W-1:0]  in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  enc_state_e        state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic              err_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;

  logic [31:0] packed_word;
  logic        packed_legal;
  logic        accept;
  logic        last_word;

  instr_pack u_pack (
    .op    (in_op),
    .rs    (in_rs),
    .rt    (in_rt),
    .rd    (in_rd),
    .imm   (in_imm),
    .word  (packed_word),
    .legal (packed_legal)
  );

  assign accept    = in_valid & in_ready;
  assign last_word = (ptr_reg == LAST_ADDR);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: clear beats start beats accept
  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = ST_IDLE;
    end else if (start) begin
      state_next = ST_LOAD;
    end else if (accept && packed_legal && last_word) begin
      state_next = ST_FULL;
    end
  end

  // Output logic. Ready is masked by start/clear so the handshake never
  // claims an accept that the control pulses would override.
  always_comb begin
    in_ready = (state_reg == ST_LOAD) && !clear && !start;
    done     = (state_reg == ST_FULL);
  end

  // Datapath: pointer, count, sticky error and the registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg   <= '0;
      count_reg <= '0;
      err_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      we_reg <= 1'b0;
      if (clear) begin
        ptr_reg   <= '0;
        count_reg <= '0;
      end else if (start) begin
        ptr_reg   <= '0;
        count_reg <= '0;
        err_reg   <= 1'b0;
      end else if (accept) begin
        if (!packed_legal) begin
          err_reg <= 1'b1;
        end else begin
          we_reg    <= 1'b1;
          addr_reg  <= ptr_reg;
          wdata_reg <= packed_word;
          count_reg <= count_reg + (ADDR_W + 1)'(1);
          // Pointer parks on the last address; FULL blocks further accepts
          if (!last_word) begin
            ptr_reg <= ptr_reg + ADDR_W'(1);
          end
        end
      end
    end
  end

  assign imem_we    = we_reg;
  assign imem_addr  = addr_reg;
  assign imem_wdata = wdata_reg;
  assign count      = count_reg;
  assign err        = err_reg;

endmodule
